// File: rtl/feature_collector.sv
// rtl/feature_collector.sv - NMS result sink: timestamped feature FIFO, flush markers, saturating stats
module feature_collector #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_feature_valid,
  input  logic                 in_isfeature,
  input  logic [15:0]          in_feature_addr,
  output logic                 ready_for_new_feature,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_addr,
  output logic [TS_WIDTH-1:0]  out_ts,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] feature_count,
  output logic [CNT_WIDTH-1:0] nonfeature_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 1 + 16 + TS_WIDTH;
  localparam logic [CW-1:0] L_DEPTH = CW'(FIFO_DEPTH);

  logic [TS_WIDTH-1:0]  r_ts;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_flush_pending;
  logic [15:0]          r_batch_cnt;
  logic [CNT_WIDTH-1:0] r_feature_count;
  logic [CNT_WIDTH-1:0] r_nonfeature_count;

  logic          w_has_room;
  logic          w_ready;
  logic          w_accept;
  logic          w_push_feat;
  logic          w_push_mark;
  logic          w_push;
  logic          w_out_valid;
  logic          w_pop;
  logic [EW-1:0] w_wr_data;
  logic [EW-1:0] w_head;

  // Room is judged on the registered count only, so a same-cycle pop never opens a full FIFO.
  assign w_has_room  = (r_count < L_DEPTH);
  assign w_ready     = !r_flush_pending && w_has_room;
  assign w_accept    = in_feature_valid && w_ready;
  assign w_push_feat = w_accept && in_isfeature;
  assign w_push_mark = r_flush_pending && w_has_room;
  assign w_push      = w_push_feat || w_push_mark;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && out_ready;
  assign w_wr_data   = w_push_mark ? {1'b1, r_batch_cnt, r_ts} : {1'b0, in_feature_addr, r_ts};
  assign w_head      = r_mem[r_rd_ptr];

  assign ready_for_new_feature = w_ready;
  assign flush_busy            = r_flush_pending;
  assign out_valid             = w_out_valid;
  assign out_addr              = w_out_valid ? w_head[TS_WIDTH +: 16] : '0;
  assign out_ts                = w_out_valid ? w_head[TS_WIDTH-1:0] : '0;
  assign out_last              = w_out_valid && w_head[EW-1];
  assign feature_count         = r_feature_count;
  assign nonfeature_count      = r_nonfeature_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // A marker write consumes the pending flush; a request arriving while pending is merged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flush_pending <= 1'b0;
      r_batch_cnt     <= '0;
    end else begin
      if (w_push_mark) begin
        r_flush_pending <= 1'b0;
        r_batch_cnt     <= '0;
      end else begin
        if (flush_req) begin
          r_flush_pending <= 1'b1;
        end
        if (w_push_feat && (r_batch_cnt != 16'hFFFF)) begin
          r_batch_cnt <= r_batch_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_feature_count    <= '0;
      r_nonfeature_count <= '0;
    end else begin
      if (w_push_feat && (r_feature_count != '1)) begin
        r_feature_count <= r_feature_count + 1'b1;
      end
      if (w_accept && !in_isfeature && (r_nonfeature_count != '1)) begin
        r_nonfeature_count <= r_nonfeature_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_feature_collector.sv
// tb/tb_feature_collector.sv - queue-model and directed-vector bench for feature_collector
module tb_feature_collector;

  logic        clk;
  logic        rst_n;
  logic        in_feature_valid;
  logic        in_isfeature;
  logic [15:0] in_feature_addr;
  logic        ready_for_new_feature;
  logic        flush_req;
  logic        flush_busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_addr;
  logic [15:0] out_ts;
  logic        out_last;
  logic [31:0] feature_count;
  logic [31:0] nonfeature_count;

  feature_collector #(.FIFO_DEPTH(16), .TS_WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_feature_valid(in_feature_valid),
    .in_isfeature(in_isfeature),
    .in_feature_addr(in_feature_addr),
    .ready_for_new_feature(ready_for_new_feature),
    .flush_req(flush_req),
    .flush_busy(flush_busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_ts(out_ts),
    .out_last(out_last),
    .feature_count(feature_count),
    .nonfeature_count(nonfeature_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        last;
    logic [15:0] addr;
    logic [15:0] ts;
  } ent_t;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  ent_t        m_q[$];
  ent_t        log_q[$];
  logic [15:0] m_ts;
  logic        m_pend;
  logic [15:0] m_batch;
  logic [31:0] m_fc;
  logic [31:0] m_nfc;
  logic        m_room;
  logic        m_acc;
  logic        m_pop;
  logic        m_mark;
  ent_t        m_e;
  ent_t        m_h;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: the FIFO is a queue, the timestamp is the cycle number since reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_ts = '0; m_pend = 1'b0; m_batch = '0; m_fc = '0; m_nfc = '0;
    end else begin
      m_room = (m_q.size() < 16);
      m_acc  = in_feature_valid && !m_pend && m_room;
      m_pop  = (m_q.size() != 0) && out_ready;
      m_mark = m_pend && m_room;
      if (m_pop) void'(m_q.pop_front());
      if (m_acc && in_isfeature) begin
        m_e.last = 1'b0; m_e.addr = in_feature_addr; m_e.ts = m_ts;
        m_q.push_back(m_e);
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        if (m_batch != 16'hFFFF) m_batch = m_batch + 1;
      end
      if (m_acc && !in_isfeature && m_nfc != 32'hFFFF_FFFF) m_nfc = m_nfc + 1;
      if (m_mark) begin
        m_e.last = 1'b1; m_e.addr = m_batch; m_e.ts = m_ts;
        m_q.push_back(m_e);
        m_batch = '0;
        m_pend  = 1'b0;
      end else if (flush_req) begin
        m_pend = 1'b1;
      end
      m_ts = m_ts + 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_q.size() != 0) m_h = m_q[0];
      else begin m_h.last = 1'b0; m_h.addr = '0; m_h.ts = '0; end
      chk("out_valid", out_valid, m_q.size() != 0);
      chk("ready", ready_for_new_feature, !m_pend && (m_q.size() < 16));
      chk("flush_busy", flush_busy, m_pend);
      chk("out_addr", out_addr, m_h.addr);
      chk("out_ts", out_ts, m_h.ts);
      chk("out_last", out_last, m_h.last);
      chk("feature_count", feature_count, m_fc);
      chk("nonfeature_count", nonfeature_count, m_nfc);
      if (out_valid && out_ready) begin
        m_e.last = out_last; m_e.addr = out_addr; m_e.ts = out_ts;
        log_q.push_back(m_e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [15:0] a, input logic f);
    int n;
    in_feature_valid = 1'b1;
    in_isfeature     = f;
    in_feature_addr  = a;
    n = 0;
    while (!ready_for_new_feature && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) chk("send_timeout", ready_for_new_feature, 1);
    cyc();
    in_feature_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    log_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_feature_valid = 1'b0; in_isfeature = 1'b0;
    in_feature_addr = '0; flush_req = 1'b0; out_ready = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ready", ready_for_new_feature, 1);
    chk("rst_busy", flush_busy, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_fc", feature_count, 0);

    // Three consecutive features
    out_ready = 1'b1;
    send(16'h0102, 1'b1);
    send(16'h0203, 1'b1);
    send(16'h0304, 1'b1);
    idle(4);
    chk("t1_n", log_q.size(), 3);
    chk("t1_a0", log_q[0].addr, 16'h0102);
    chk("t1_a1", log_q[1].addr, 16'h0203);
    chk("t1_a2", log_q[2].addr, 16'h0304);
    chk("t1_last", log_q[2].last, 0);
    chk("t1_dts0", log_q[1].ts - log_q[0].ts, 1);
    chk("t1_dts1", log_q[2].ts - log_q[1].ts, 1);
    chk("t1_fc", feature_count, 3);

    // Non-features interleaved with one feature
    do_reset();
    send(16'h0501, 1'b0);
    send(16'h0502, 1'b0);
    send(16'h0A0A, 1'b1);
    send(16'h0503, 1'b0);
    send(16'h0504, 1'b0);
    idle(4);
    chk("t2_n", log_q.size(), 1);
    chk("t2_a", log_q[0].addr, 16'h0A0A);
    chk("t2_nfc", nonfeature_count, 4);
    chk("t2_fc", feature_count, 1);

    // Fill to full, single pop, then the held 17th goes in
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(16'h1000 + 16'(i), 1'b1);
    in_feature_valid = 1'b1; in_isfeature = 1'b1; in_feature_addr = 16'h1010;
    idle(3);
    chk("t3_full_ready", ready_for_new_feature, 0);
    chk("t3_fc16", feature_count, 16);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("t3_ready_after_pop", ready_for_new_feature, 1);
    chk("t3_fc_hold", feature_count, 16);
    cyc();
    in_feature_valid = 1'b0;
    chk("t3_fc17", feature_count, 17);
    out_ready = 1'b1;
    idle(20);
    chk("t3_n", log_q.size(), 17);
    chk("t3_first", log_q[0].addr, 16'h1000);
    chk("t3_17th", log_q[16].addr, 16'h1010);

    // Five features, flush, then an empty flush
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(16'h2000 + 16'(i), 1'b1);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    chk("t4_busy", flush_busy, 1);
    chk("t4_ready_pend", ready_for_new_feature, 0);
    cyc();
    chk("t4_busy_clr", flush_busy, 0);
    idle(5);
    chk("t4_n", log_q.size(), 6);
    chk("t4_feat_last", log_q[4].last, 0);
    chk("t4_mark_last", log_q[5].last, 1);
    chk("t4_mark_cnt", log_q[5].addr, 5);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    idle(5);
    chk("t4_n2", log_q.size(), 7);
    chk("t4_mark2_last", log_q[6].last, 1);
    chk("t4_mark2_cnt", log_q[6].addr, 0);

    // Flush in the same cycle as an accepted feature
    do_reset();
    in_feature_valid = 1'b1; in_isfeature = 1'b1; in_feature_addr = 16'h0BEE;
    flush_req = 1'b1;
    cyc();
    in_feature_valid = 1'b0; flush_req = 1'b0;
    chk("t5_busy", flush_busy, 1);
    chk("t5_ready", ready_for_new_feature, 0);
    idle(5);
    chk("t5_n", log_q.size(), 2);
    chk("t5_feat", log_q[0].addr, 16'h0BEE);
    chk("t5_mark_last", log_q[1].last, 1);
    chk("t5_mark_cnt", log_q[1].addr, 1);

    // Reset with 7 entries held and a flush pending
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(16'h3000 + 16'(i), 1'b1);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    chk("t6_busy", flush_busy, 1);
    chk("t6_valid", out_valid, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    log_q.delete();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", flush_busy, 0);
    chk("t6_rst_fc", feature_count, 0);
    chk("t6_rst_nfc", nonfeature_count, 0);
    chk("t6_rst_ready", ready_for_new_feature, 1);
    out_ready = 1'b1;
    idle(20);
    chk("t6_no_stale", log_q.size(), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
